// File: rtl/spi_master_host_if.sv
// Control/status handshake and SPI pin bundle of spi_master_host.
// The master modport is the SPI initiator's view; the slave modport is the host/pin-side view.
interface spi_master_host_if #(
  parameter int DATA_WIDTH = 32
);
  // start_i is taken on any clk edge where busy_o=0; busy_o is high from the next
  // cycle until the done cycle, where done_o pulses once and busy_o is already low.
  logic                  start_i;
  logic                  quad_i;
  logic                  wr_i;
  logic [7:0]            cmd_i;
  logic                  addr_en_i;
  logic [31:0]           addr_i;
  logic [7:0]            dummy_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  spi_clk_o;
  logic                  spi_cs_o;
  logic                  spi_sdo0_o;
  logic                  spi_sdo1_o;
  logic                  spi_sdo2_o;
  logic                  spi_sdo3_o;
  logic [3:0]            spi_oe_o;
  logic                  spi_sdi0_i;
  logic                  spi_sdi1_i;
  logic                  spi_sdi2_i;
  logic                  spi_sdi3_i;
  logic [2:0]            state_o;

  modport master (
    input  start_i, quad_i, wr_i, cmd_i, addr_en_i, addr_i, dummy_i, data_i,
    input  spi_sdi0_i, spi_sdi1_i, spi_sdi2_i, spi_sdi3_i,
    output data_o, busy_o, done_o, state_o,
    output spi_clk_o, spi_cs_o, spi_sdo0_o, spi_sdo1_o, spi_sdo2_o, spi_sdo3_o, spi_oe_o
  );

  modport slave (
    output start_i, quad_i, wr_i, cmd_i, addr_en_i, addr_i, dummy_i, data_i,
    output spi_sdi0_i, spi_sdi1_i, spi_sdi2_i, spi_sdi3_i,
    input  data_o, busy_o, done_o, state_o,
    input  spi_clk_o, spi_cs_o, spi_sdo0_o, spi_sdo1_o, spi_sdo2_o, spi_sdo3_o, spi_oe_o
  );
endinterface

// File: rtl/spi_master_host.sv
// Mode-0 SPI initiator: one transaction per start (cmd, optional address, dummy, data),
// single-lane command with optional quad-lane address/data.
module spi_master_host #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_host_if.master bus
);
  localparam int SR_W  = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam int CNT_W = (SR_W > 256) ? $clog2(SR_W) : 8;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_ADDR  = 3'd3;
  localparam logic [2:0] ST_DUMMY = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;

  logic [2:0]            state;
  logic [2:0]            next_phase;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_wrap;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      phase_last;
  logic                  sck;
  logic                  done;
  logic                  quad_q;
  logic                  wr_q;
  logic                  addr_en_q;
  logic [7:0]            dummy_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [SR_W-1:0]       tx_sr;
  logic [SR_W-1:0]       next_load;
  logic [3:0]            sdi;
  logic [3:0]            lanes;
  logic [3:0]            oe;
  logic                  rd_phase;

  assign sdi      = {bus.spi_sdi3_i, bus.spi_sdi2_i, bus.spi_sdi1_i, bus.spi_sdi0_i};
  assign div_wrap = (div_cnt == DIV_LAST);
  assign rd_phase = (state == ST_DATA) && !wr_q;

  // Length of the current shifting phase and what follows it; the shift register is
  // reloaded left-aligned with the next phase's payload on the last falling edge.
  always_comb begin
    phase_last = CNT_W'(7);
    next_phase = ST_HOLD;
    next_load  = SR_W'(data_q) << (SR_W - DATA_WIDTH);
    case (state)
      ST_CMD: begin
        phase_last = CNT_W'(7);
        if (addr_en_q)           next_phase = ST_ADDR;
        else if (dummy_q != 8'd0) next_phase = ST_DUMMY;
        else                     next_phase = ST_DATA;
      end
      ST_ADDR: begin
        phase_last = quad_q ? CNT_W'(7) : CNT_W'(31);
        next_phase = (dummy_q != 8'd0) ? ST_DUMMY : ST_DATA;
      end
      ST_DUMMY: begin
        phase_last = CNT_W'(dummy_q) - CNT_W'(1);
        next_phase = ST_DATA;
      end
      ST_DATA: begin
        phase_last = quad_q ? CNT_W'(DATA_WIDTH / 4 - 1) : CNT_W'(DATA_WIDTH - 1);
        next_phase = ST_HOLD;
      end
      default: ;
    endcase
    if (next_phase == ST_ADDR) next_load = SR_W'(addr_q) << (SR_W - 32);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sck       <= 1'b0;
      done      <= 1'b0;
      quad_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_en_q <= 1'b0;
      dummy_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      data_rd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            quad_q    <= bus.quad_i;
            wr_q      <= bus.wr_i;
            addr_en_q <= bus.addr_en_i;
            dummy_q   <= bus.dummy_i;
            addr_q    <= bus.addr_i;
            data_q    <= bus.data_i;
            tx_sr     <= SR_W'(bus.cmd_i) << (SR_W - 8);
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_CMD;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
          if (!div_wrap) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sck) begin
              // Rising SCK edge: the slave's bit has been stable for a full low half.
              sck <= 1'b1;
              if (rd_phase) begin
                rx_sr <= quad_q ? ((rx_sr << 4) | DATA_WIDTH'(sdi))
                                : ((rx_sr << 1) | DATA_WIDTH'(sdi[0]));
              end
            end else begin
              sck <= 1'b0;
              if (bit_cnt == phase_last) begin
                bit_cnt <= '0;
                state   <= next_phase;
                tx_sr   <= next_load;
                if (rd_phase) data_rd <= rx_sr;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sr   <= (quad_q && state != ST_CMD) ? (tx_sr << 4) : (tx_sr << 1);
              end
            end
          end
        end
        ST_HOLD: begin
          if (div_wrap) begin
            div_cnt <= '0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lanes are driven only while the host owns them; DUMMY, read data and HOLD float (oe=0).
  always_comb begin
    oe    = 4'b0000;
    lanes = 4'b0000;
    case (state)
      ST_SETUP, ST_CMD: begin
        oe       = 4'b0001;
        lanes[0] = tx_sr[SR_W-1];
      end
      ST_ADDR, ST_DATA: begin
        if (state == ST_ADDR || wr_q) begin
          if (quad_q) begin
            oe    = 4'b1111;
            lanes = tx_sr[SR_W-1 -: 4];
          end else begin
            oe       = 4'b0001;
            lanes[0] = tx_sr[SR_W-1];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.spi_clk_o  = sck;
  assign bus.spi_cs_o   = (state == ST_IDLE);
  assign bus.busy_o     = (state != ST_IDLE);
  assign bus.done_o     = done;
  assign bus.data_o     = data_rd;
  assign bus.state_o    = state;
  assign bus.spi_oe_o   = oe;
  assign bus.spi_sdo0_o = lanes[0];
  assign bus.spi_sdo1_o = lanes[1];
  assign bus.spi_sdo2_o = lanes[2];
  assign bus.spi_sdo3_o = lanes[3];
endmodule

// File: tb/tb_spi_master_host.sv
// Bench for spi_master_host: two instances (CLK_DIV=2 and CLK_DIV=1), an SPI slave model,
// per-SCK-rise capture, and a transaction-level reference for the pin stream and data_o.
module tb_spi_master_host;
  localparam int DW     = 32;
  localparam int CD_A   = 2;
  localparam int CD_B   = 1;
  localparam int CLK_P  = 10;
  localparam int BUDGET = 4000;

  typedef struct {
    bit          quad;
    bit          wr;
    bit          addr_en;
    logic [7:0]  cmd;
    logic [31:0] addr;
    int          dummy;
    logic [DW-1:0] data;
    logic [DW-1:0] rd_word;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #(CLK_P / 2) clk = ~clk;

  spi_master_host_if #(.DATA_WIDTH(DW)) a_if ();
  spi_master_host_if #(.DATA_WIDTH(DW)) b_if ();

  spi_master_host #(.CLK_DIV(CD_A), .DATA_WIDTH(DW)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
  spi_master_host #(.CLK_DIV(CD_B), .DATA_WIDTH(DW)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

  int checks = 0;
  int failures = 0;

  // Scoreboard: one entry per SCK rise, {oe[3:0], sdo3..sdo0}
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] cap_b[$];
  logic [DW-1:0] exp_data_o = '0;

  int  cs_viol_a, per_viol_a, cs_viol_b, per_viol_b, done_a;
  bit  have_rise_a, have_rise_b;
  time last_rise_a, last_rise_b;

  // Slave model state (dut_a only)
  int          s_idx = 0;
  int          slv_pre = 0;
  bit          slv_quad = 0;
  logic [DW-1:0] slv_word = '0;

  always @(posedge a_if.spi_clk_o) begin
    cap_q.push_back({a_if.spi_oe_o, a_if.spi_sdo3_o, a_if.spi_sdo2_o, a_if.spi_sdo1_o, a_if.spi_sdo0_o});
    if (a_if.spi_cs_o !== 1'b0) cs_viol_a++;
    if (have_rise_a && ($time - last_rise_a) != 2 * CD_A * CLK_P) per_viol_a++;
    have_rise_a = 1;
    last_rise_a = $time;
    s_idx++;
  end

  always @(posedge b_if.spi_clk_o) begin
    cap_b.push_back({b_if.spi_oe_o, b_if.spi_sdo3_o, b_if.spi_sdo2_o, b_if.spi_sdo1_o, b_if.spi_sdo0_o});
    if (b_if.spi_cs_o !== 1'b0) cs_viol_b++;
    if (have_rise_b && ($time - last_rise_b) != 2 * CD_B * CLK_P) per_viol_b++;
    have_rise_b = 1;
    last_rise_b = $time;
  end

  always @(negedge clk) if (a_if.done_o === 1'b1) done_a++;

  // Slave presents read bit/nibble j = (SCK rises so far) - (cmd+addr+dummy cycles), mode 0.
  task automatic slave_drive();
    int j;
    logic [3:0] v;
    j = s_idx - slv_pre;
    v = 4'b0000;
    if (j >= 0) begin
      if (slv_quad && j < DW / 4) v = slv_word[DW-1-4*j -: 4];
      else if (!slv_quad && j < DW) v = {3'b000, slv_word[DW-1-j]};
    end
    {a_if.spi_sdi3_i, a_if.spi_sdi2_i, a_if.spi_sdi1_i, a_if.spi_sdi0_i} = v;
  endtask

  always @(negedge a_if.spi_cs_o) begin
    s_idx = 0;
    slave_drive();
  end
  always @(negedge a_if.spi_clk_o) slave_drive();

  // Reference pin stream of one transaction, built from the phase rules.
  function automatic void build_exp(txn_t t);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({4'b0001, 3'b000, t.cmd[7-i]});
    if (t.addr_en) begin
      if (t.quad) for (int n = 0; n < 8; n++) exp_q.push_back({4'b1111, t.addr[31-4*n -: 4]});
      else        for (int n = 0; n < 32; n++) exp_q.push_back({4'b0001, 3'b000, t.addr[31-n]});
    end
    for (int n = 0; n < t.dummy; n++) exp_q.push_back(8'h00);
    if (t.wr) begin
      if (t.quad) for (int n = 0; n < DW / 4; n++) exp_q.push_back({4'b1111, t.data[DW-1-4*n -: 4]});
      else        for (int n = 0; n < DW; n++) exp_q.push_back({4'b0001, 3'b000, t.data[DW-1-n]});
    end else begin
      for (int n = 0; n < (t.quad ? DW / 4 : DW); n++) exp_q.push_back(8'h00);
    end
  endfunction

  // Index of the first differing entry (driven lanes only), or -1.
  function automatic int first_mismatch(input logic [7:0] got[$]);
    logic [7:0] c;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      c = got[i];
      if ({c[7:4], c[3:0] & c[7:4]} !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.quad    = 1'($urandom_range(0, 1));
    t.wr      = 1'($urandom_range(0, 1));
    t.addr_en = 1'($urandom_range(0, 1));
    t.cmd     = 8'($urandom);
    t.addr    = $urandom;
    t.dummy   = $urandom_range(0, 4);
    t.data    = DW'($urandom);
    t.rd_word = DW'($urandom);
    return t;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting clk edge.
  task automatic start_txn(txn_t t);
    a_if.quad_i    = t.quad;
    a_if.wr_i      = t.wr;
    a_if.addr_en_i = t.addr_en;
    a_if.cmd_i     = t.cmd;
    a_if.addr_i    = t.addr;
    a_if.dummy_i   = 8'(t.dummy);
    a_if.data_i    = t.data;
    build_exp(t);
    slv_quad = t.quad;
    slv_word = t.rd_word;
    slv_pre  = 8 + (t.addr_en ? (t.quad ? 8 : 32) : 0) + t.dummy;
    cap_q.delete();
    have_rise_a = 0;
    cs_viol_a = 0;
    per_viol_a = 0;
    if (!t.wr) exp_data_o = t.rd_word;
    a_if.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.start_i = 1'b0;
  endtask

  // Clk edges after the accepting edge until done_o is seen high.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok = 0;
    while (cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (a_if.done_o === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_if.spi_cs_o !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", a_if.spi_cs_o); end
    checks++; if (a_if.spi_clk_o !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", a_if.spi_clk_o); end
    checks++; if (a_if.spi_oe_o !== 4'b0000) begin failures++; $display("FAIL reset_oe got=%b exp=0000", a_if.spi_oe_o); end
    checks++; if ({a_if.spi_sdo3_o, a_if.spi_sdo2_o, a_if.spi_sdo1_o, a_if.spi_sdo0_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_sdo got=%b exp=0000", {a_if.spi_sdo3_o, a_if.spi_sdo2_o, a_if.spi_sdo1_o, a_if.spi_sdo0_o});
    end
    checks++; if ({a_if.busy_o, a_if.done_o} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {a_if.busy_o, a_if.done_o}); end
    checks++; if (a_if.data_o !== '0) begin failures++; $display("FAIL reset_data_o got=%h exp=0", a_if.data_o); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({a_if.spi_cs_o, a_if.busy_o} !== 2'b10) begin failures++; $display("FAIL idle_after_reset cs_busy=%b exp=10", {a_if.spi_cs_o, a_if.busy_o}); end
  endtask

  task automatic test_std_write();
    txn_t t;
    int cyc, mm;
    bit ok;
    t = '{quad: 0, wr: 1, addr_en: 1, cmd: 8'h02, addr: 32'h0000_1000, dummy: 0,
          data: 32'hDEAD_BEEF, rd_word: '0};
    start_txn(t);
    checks++; if ({a_if.busy_o, a_if.spi_cs_o} !== 2'b10) begin failures++; $display("FAIL t1_busy_cs_after_start got=%b exp=10", {a_if.busy_o, a_if.spi_cs_o}); end
    wait_done(cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t1_done_timeout waited=%0d", cyc); end
    checks++; if (cyc !== 72 * 2 * CD_A + 2 * CD_A) begin failures++; $display("FAIL t1_latency got=%0d exp=%0d", cyc, 72 * 2 * CD_A + 2 * CD_A); end
    checks++; if (cap_q.size() !== 72) begin failures++; $display("FAIL t1_sck_rises got=%0d exp=72", cap_q.size()); end
    mm = first_mismatch(cap_q);
    checks++; if (mm !== -1) begin failures++; $display("FAIL t1_sdo_stream idx=%0d got=%h exp=%h", mm, cap_q[mm], exp_q[mm]); end
    checks++; if (cs_viol_a !== 0 || per_viol_a !== 0) begin failures++; $display("FAIL t1_cs_period cs_viol=%0d per_viol=%0d exp=0/0", cs_viol_a, per_viol_a); end
    checks++; if ({a_if.busy_o, a_if.spi_cs_o, a_if.spi_oe_o} !== 6'b010000) begin
      failures++; $display("FAIL t1_done_cycle busy_cs_oe=%b exp=010000", {a_if.busy_o, a_if.spi_cs_o, a_if.spi_oe_o});
    end
    checks++; if (a_if.data_o !== exp_data_o) begin failures++; $display("FAIL t1_data_o_unchanged got=%h exp=%h", a_if.data_o, exp_data_o); end
    @(negedge clk);
    checks++; if (a_if.done_o !== 1'b0) begin failures++; $display("FAIL t1_done_one_cycle got=%b exp=0", a_if.done_o); end
  endtask

  task automatic test_read(input bit quad, input bit addr_en, input logic [7:0] cmd,
                           input logic [31:0] addr, input int dummy, input logic [DW-1:0] word,
                           input int exp_rises, input string tag);
    txn_t t;
    int cyc, mm;
    bit ok;
    t = '{quad: quad, wr: 0, addr_en: addr_en, cmd: cmd, addr: addr, dummy: dummy,
          data: DW'($urandom), rd_word: word};
    start_txn(t);
    wait_done(cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_done_timeout waited=%0d", tag, cyc); end
    checks++; if (cap_q.size() !== exp_rises) begin failures++; $display("FAIL %s_sck_rises got=%0d exp=%0d", tag, cap_q.size(), exp_rises); end
    mm = first_mismatch(cap_q);
    checks++; if (mm !== -1) begin failures++; $display("FAIL %s_lane_stream idx=%0d got=%h exp=%h", tag, mm, cap_q[mm], exp_q[mm]); end
    checks++; if (a_if.data_o !== word) begin failures++; $display("FAIL %s_data_o got=%h exp=%h", tag, a_if.data_o, word); end
    checks++; if (cyc !== exp_rises * 2 * CD_A + 2 * CD_A) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, cyc, exp_rises * 2 * CD_A + 2 * CD_A); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    txn_t t;
    int cyc, mm;
    bit ok;
    t = rand_txn();
    t.wr = 1;
    done_a = 0;
    start_txn(t);
    repeat (30) @(negedge clk);
    a_if.cmd_i = ~t.cmd;
    a_if.data_i = ~t.data;
    a_if.quad_i = ~t.quad;
    a_if.start_i = 1'b1;
    @(negedge clk);
    a_if.start_i = 1'b0;
    wait_done(cyc, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL t4_done_timeout waited=%0d", cyc); end
    mm = first_mismatch(cap_q);
    checks++; if (mm !== -1 || cap_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL t4_stream_unaffected idx=%0d rises=%0d exp_rises=%0d", mm, cap_q.size(), exp_q.size());
    end
    checks++; if (done_a !== 1) begin failures++; $display("FAIL t4_done_count got=%0d exp=1", done_a); end
  endtask

  task automatic test_back_to_back();
    txn_t t1, t2;
    int cyc, mm;
    bit ok;
    t1 = rand_txn(); t1.wr = 0; t1.quad = 0;
    t2 = rand_txn(); t2.wr = 1; t2.quad = 1;
    start_txn(t1);
    wait_done(cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first_done_timeout waited=%0d", cyc); end
    mm = first_mismatch(cap_q);
    checks++; if (mm !== -1 || cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_first_stream idx=%0d rises=%0d exp_rises=%0d", mm, cap_q.size(), exp_q.size()); end
    checks++; if (a_if.data_o !== t1.rd_word) begin failures++; $display("FAIL b2b_first_data_o got=%h exp=%h", a_if.data_o, t1.rd_word); end
    checks++; if ({a_if.spi_cs_o, a_if.busy_o} !== 2'b10) begin failures++; $display("FAIL b2b_gap_cs_busy got=%b exp=10", {a_if.spi_cs_o, a_if.busy_o}); end
    start_txn(t2);
    checks++; if (a_if.spi_cs_o !== 1'b0) begin failures++; $display("FAIL b2b_second_accepted cs=%b exp=0", a_if.spi_cs_o); end
    wait_done(cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_second_done_timeout waited=%0d", cyc); end
    mm = first_mismatch(cap_q);
    checks++; if (mm !== -1 || cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_second_stream idx=%0d rises=%0d exp_rises=%0d", mm, cap_q.size(), exp_q.size()); end
    checks++; if (a_if.data_o !== t1.rd_word) begin failures++; $display("FAIL b2b_write_keeps_data_o got=%h exp=%h", a_if.data_o, t1.rd_word); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    txn_t t;
    int n;
    t = rand_txn(); t.quad = 0; t.addr_en = 1; t.wr = 0;
    start_txn(t);
    n = 0;
    while (cap_q.size() < 12 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cap_q.size() < 12) begin failures++; $display("FAIL t5_reach_addr rises=%0d exp>=12", cap_q.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({a_if.spi_cs_o, a_if.spi_clk_o, a_if.spi_oe_o} !== 6'b100000) begin
      failures++; $display("FAIL t5_async_pins cs_sck_oe=%b exp=100000", {a_if.spi_cs_o, a_if.spi_clk_o, a_if.spi_oe_o});
    end
    checks++; if ({a_if.busy_o, a_if.done_o} !== 2'b00 || a_if.data_o !== '0) begin
      failures++; $display("FAIL t5_async_status busy_done=%b data_o=%h exp=00/0", {a_if.busy_o, a_if.done_o}, a_if.data_o);
    end
    exp_data_o = '0;
    @(negedge clk);
    rst = 1'b0;
    done_a = 0;
    repeat (60) @(negedge clk);
    checks++; if (done_a !== 0) begin failures++; $display("FAIL t5_no_done got=%0d exp=0", done_a); end
    test_read(1, 1, 8'hEB, $urandom, 2, DW'($urandom), 8 + 8 + 2 + 8, "t5_after");
  endtask

  task automatic test_random(input int count);
    txn_t t;
    int cyc, mm;
    bit ok;
    for (int k = 0; k < count; k++) begin
      t = rand_txn();
      start_txn(t);
      wait_done(cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_done_timeout waited=%0d", k, cyc); end
      checks++; if (cap_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd%0d_sck_rises got=%0d exp=%0d", k, cap_q.size(), exp_q.size()); end
      mm = first_mismatch(cap_q);
      checks++; if (mm !== -1) begin failures++; $display("FAIL rnd%0d_stream idx=%0d got=%h exp=%h", k, mm, cap_q[mm], exp_q[mm]); end
      checks++; if (a_if.data_o !== exp_data_o) begin failures++; $display("FAIL rnd%0d_data_o got=%h exp=%h", k, a_if.data_o, exp_data_o); end
      checks++; if (cyc !== exp_q.size() * 2 * CD_A + 2 * CD_A) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, cyc, exp_q.size() * 2 * CD_A + 2 * CD_A); end
      checks++; if (cs_viol_a !== 0 || per_viol_a !== 0) begin failures++; $display("FAIL rnd%0d_cs_period cs_viol=%0d per_viol=%0d exp=0/0", k, cs_viol_a, per_viol_a); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_clkdiv1();
    txn_t t;
    int cyc, mm;
    logic [7:0] last;
    t = '{quad: 0, wr: 1, addr_en: 0, cmd: 8'h02, addr: '0, dummy: 0, data: 32'h0000_0001, rd_word: '0};
    build_exp(t);
    cap_b.delete();
    have_rise_b = 0; cs_viol_b = 0; per_viol_b = 0;
    b_if.quad_i = 0; b_if.wr_i = 1; b_if.addr_en_i = 0; b_if.cmd_i = t.cmd;
    b_if.addr_i = '0; b_if.dummy_i = '0; b_if.data_i = t.data;
    b_if.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_if.start_i = 1'b0;
    cyc = 0;
    while (cyc < BUDGET && b_if.done_o !== 1'b1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checks++; if (b_if.done_o !== 1'b1) begin failures++; $display("FAIL t6_done_timeout waited=%0d", cyc); end
    checks++; if (cyc !== 40 * 2 * CD_B + 2 * CD_B) begin failures++; $display("FAIL t6_latency got=%0d exp=%0d", cyc, 40 * 2 * CD_B + 2 * CD_B); end
    checks++; if (cap_b.size() !== 40) begin failures++; $display("FAIL t6_sck_rises got=%0d exp=40", cap_b.size()); end
    mm = first_mismatch(cap_b);
    checks++; if (mm !== -1) begin failures++; $display("FAIL t6_stream idx=%0d got=%h exp=%h", mm, cap_b[mm], exp_q[mm]); end
    last = (cap_b.size() > 0) ? cap_b[cap_b.size()-1] : 8'h00;
    checks++; if (last[0] !== 1'b1) begin failures++; $display("FAIL t6_last_sdo0 got=%b exp=1", last[0]); end
    checks++; if (per_viol_b !== 0 || cs_viol_b !== 0) begin failures++; $display("FAIL t6_period per_viol=%0d cs_viol=%0d exp=0/0", per_viol_b, cs_viol_b); end
  endtask

  initial begin
    a_if.start_i = 0; a_if.quad_i = 0; a_if.wr_i = 0; a_if.cmd_i = '0; a_if.addr_en_i = 0;
    a_if.addr_i = '0; a_if.dummy_i = '0; a_if.data_i = '0;
    b_if.start_i = 0; b_if.quad_i = 0; b_if.wr_i = 0; b_if.cmd_i = '0; b_if.addr_en_i = 0;
    b_if.addr_i = '0; b_if.dummy_i = '0; b_if.data_i = '0;
    b_if.spi_sdi0_i = 0; b_if.spi_sdi1_i = 0; b_if.spi_sdi2_i = 0; b_if.spi_sdi3_i = 0;
    test_reset();
    test_std_write();
    test_read(1, 1, 8'h0B, 32'h1A10_2000, 8, 32'h1234_5678, 32, "t2_quad_read");
    test_read(0, 0, 8'h05, 32'h0, 0, 32'hA5A5_0001, 40, "t3_std_read");
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random(12);
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(CLK_P * 90000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
